// File: rtl/cnn_sdiv_seq_25s_10s_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cnn_sdiv_seq_25s_10s_if                                                  |
// | Operand and result handshake bundle for the sequential signed divider.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface cnn_sdiv_seq_25s_10s_if #(
  parameter int DIVIDEND_W = 25,
  parameter int DIVISOR_W  = 10,
  parameter int QUOT_W     = 14
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [QUOT_W-1:0]     quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;
  logic                  overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
endinterface
`default_nettype wire

// File: rtl/cnn_sdiv_seq_25s_10s.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cnn_sdiv_seq_25s_10s                                                     |
// | Radix-2 restoring signed divider, saturated quotient, C-style remainder. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cnn_sdiv_seq_25s_10s #(
  parameter int DIVIDEND_W = 25,
  parameter int DIVISOR_W  = 10,
  parameter int QUOT_W     = 14
) (
  input  wire logic              ap_clk,
  input  wire logic              ap_rst_n,
  cnn_sdiv_seq_25s_10s_if.slave  io
);
  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0]      c_LAST = CNT_W'(DIVIDEND_W - 1);
  localparam logic [DIVIDEND_W-1:0] c_QMAX = DIVIDEND_W'((1 << (QUOT_W - 1)) - 1);
  localparam logic [DIVIDEND_W-1:0] c_QMIN_MAG = DIVIDEND_W'(1 << (QUOT_W - 1));
  localparam logic [QUOT_W-1:0]     c_QPOS = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic [QUOT_W-1:0]     c_QNEG = {1'b1, {(QUOT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state, w_next;
  logic   w_in_ready, w_out_valid, w_load, w_step, w_fix;

  // Holds in_ready low until the first edge after reset release.
  logic                  r_live;
  logic [CNT_W-1:0]      r_cnt;
  // Dividend magnitude shifts out MSB-first while quotient bits shift in.
  logic [DIVIDEND_W-1:0] r_dvd;
  logic [DIVISOR_W-1:0]  r_dsr;
  logic [DIVISOR_W:0]    r_rem;
  logic                  r_sign_q, r_sign_r, r_dz;
  logic [QUOT_W-1:0]     r_quot;
  logic [DIVISOR_W-1:0]  r_rmd;
  logic                  r_dbz, r_ovf;

  logic [DIVIDEND_W-1:0] w_abs_dvd;
  logic [DIVISOR_W-1:0]  w_abs_dsr;
  logic [DIVISOR_W:0]    w_trial, w_sub;
  logic                  w_ge;
  logic [QUOT_W-1:0]     w_quot;
  logic [DIVISOR_W-1:0]  w_rmd;
  logic                  w_ovf;

  assign w_abs_dvd = io.dividend[DIVIDEND_W-1] ? (~io.dividend + 1'b1) : io.dividend;
  assign w_abs_dsr = io.divisor[DIVISOR_W-1]   ? (~io.divisor + 1'b1)  : io.divisor;
  assign w_trial   = {r_rem[DIVISOR_W-1:0], r_dvd[DIVIDEND_W-1]};
  assign w_ge      = (w_trial >= {1'b0, r_dsr});
  assign w_sub     = w_trial - {1'b0, r_dsr};

  always_comb begin
    w_quot = '0;
    w_rmd  = '0;
    w_ovf  = 1'b0;
    if (r_dz) begin
      w_quot = r_sign_r ? c_QNEG : c_QPOS;
    end else begin
      if (r_sign_q) begin
        w_ovf  = (r_dvd > c_QMIN_MAG);
        w_quot = w_ovf ? c_QNEG : (~r_dvd[QUOT_W-1:0] + 1'b1);
      end else begin
        w_ovf  = (r_dvd > c_QMAX);
        w_quot = w_ovf ? c_QPOS : r_dvd[QUOT_W-1:0];
      end
      w_rmd = r_sign_r ? (~r_rem[DIVISOR_W-1:0] + 1'b1) : r_rem[DIVISOR_W-1:0];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_fix       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = r_live;
        if (r_live && io.in_valid) begin
          w_load = 1'b1;
          w_next = S_CALC;
        end
      end
      S_CALC: begin
        w_step = 1'b1;
        if (r_cnt == c_LAST) w_next = S_FIX;
      end
      S_FIX: begin
        w_fix  = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (io.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_live   <= 1'b0;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_rem    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_dz     <= 1'b0;
      r_quot   <= '0;
      r_rmd    <= '0;
      r_dbz    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_load) begin
        r_cnt    <= '0;
        r_dvd    <= w_abs_dvd;
        r_dsr    <= w_abs_dsr;
        r_rem    <= '0;
        r_sign_q <= io.dividend[DIVIDEND_W-1] ^ io.divisor[DIVISOR_W-1];
        r_sign_r <= io.dividend[DIVIDEND_W-1];
        r_dz     <= (io.divisor == '0);
      end
      if (w_step) begin
        r_cnt <= r_cnt + 1'b1;
        r_rem <= w_ge ? w_sub : w_trial;
        r_dvd <= {r_dvd[DIVIDEND_W-2:0], w_ge};
      end
      if (w_fix) begin
        r_quot <= w_quot;
        r_rmd  <= w_rmd;
        r_dbz  <= r_dz;
        r_ovf  <= w_ovf;
      end
    end
  end

  assign io.in_ready    = w_in_ready;
  assign io.out_valid   = w_out_valid;
  assign io.quotient    = r_quot;
  assign io.remainder   = r_rmd;
  assign io.div_by_zero = r_dbz;
  assign io.overflow    = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_cnn_sdiv_seq_25s_10s.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cnn_sdiv_seq_25s_10s                                                  |
// | Directed self-checking bench for the sequential signed divider.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cnn_sdiv_seq_25s_10s;
  logic clk;
  logic rst_n;
  int   n_err;
  int   n_chk;

  cnn_sdiv_seq_25s_10s_if #(.DIVIDEND_W(25), .DIVISOR_W(10), .QUOT_W(14)) ifc ();

  cnn_sdiv_seq_25s_10s #(.DIVIDEND_W(25), .DIVISOR_W(10), .QUOT_W(14)) dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .io       (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_div(input logic signed [24:0] a, input logic signed [9:0] b);
    int t;
    t = 0;
    while (!ifc.in_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (!ifc.in_ready) begin
      n_chk++; n_err++;
      $display("FAIL start_timeout in_ready=%0b required=1", ifc.in_ready);
    end
    ifc.dividend = a;
    ifc.divisor  = b;
    ifc.in_valid = 1'b1;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!ifc.out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic consume();
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (ifc.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b exp=0", ifc.out_valid); end
    n_chk++; if (ifc.quotient !== 14'd0) begin n_err++; $display("FAIL rst_quotient got=%0d exp=0", ifc.quotient); end
    n_chk++; if (ifc.remainder !== 10'd0) begin n_err++; $display("FAIL rst_remainder got=%0d exp=0", ifc.remainder); end
    n_chk++; if ({ifc.div_by_zero, ifc.overflow} !== 2'b00) begin n_err++; $display("FAIL rst_flags got=%b exp=00", {ifc.div_by_zero, ifc.overflow}); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (ifc.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%b exp=1", ifc.in_ready); end
  endtask

  task automatic test_vectors();
    int va[9], vb[9], vq[9], vr[9], vz[9], vo[9];
    int lat;
    logic signed [13:0] eq;
    logic signed [9:0]  er;
    va = '{1000, -1000, 1000, -8192, 500, -500, 16000000, -16777216, -512};
    vb = '{7, 7, -7, 1, 0, 0, 3, 1, -512};
    vq = '{142, -142, -142, -8192, 8191, -8192, 8191, -8192, 1};
    vr = '{6, -6, 6, 0, 0, 0, 1, 0, 0};
    vz = '{0, 0, 0, 0, 1, 1, 0, 0, 0};
    vo = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
    for (int i = 0; i < 9; i++) begin
      start_div(25'(va[i]), 10'(vb[i]));
      wait_out(lat);
      eq = 14'(vq[i]);
      er = 10'(vr[i]);
      n_chk++; if (lat != 26) begin n_err++; $display("FAIL vec%0d_latency got=%0d exp=26", i, lat); end
      n_chk++; if (ifc.quotient !== eq) begin n_err++; $display("FAIL vec%0d_quotient got=%0d exp=%0d", i, $signed(ifc.quotient), eq); end
      n_chk++; if (ifc.remainder !== er) begin n_err++; $display("FAIL vec%0d_remainder got=%0d exp=%0d", i, $signed(ifc.remainder), er); end
      n_chk++; if ({ifc.div_by_zero, ifc.overflow} !== {vz[i][0], vo[i][0]}) begin
        n_err++; $display("FAIL vec%0d_flags got=%b exp=%b", i, {ifc.div_by_zero, ifc.overflow}, {vz[i][0], vo[i][0]});
      end
      consume();
      n_chk++; if (ifc.out_valid !== 1'b0) begin n_err++; $display("FAIL vec%0d_consume got=%b exp=0", i, ifc.out_valid); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int seen;
    start_div(25'sd1000, 10'sd7);
    wait_out(lat);
    ifc.in_valid = 1'b1;
    ifc.dividend = 25'sd99;
    ifc.divisor  = 10'sd2;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if (ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b0 || ifc.quotient !== 14'sd142 || ifc.remainder !== 10'sd6) begin
        n_err++;
        $display("FAIL bp_hold%0d got v=%b rdy=%b q=%0d r=%0d exp v=1 rdy=0 q=142 r=6",
                 i, ifc.out_valid, ifc.in_ready, $signed(ifc.quotient), $signed(ifc.remainder));
      end
    end
    ifc.in_valid  = 1'b0;
    consume();
    n_chk++; if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_release got rdy=%b v=%b exp rdy=1 v=0", ifc.in_ready, ifc.out_valid);
    end
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (ifc.out_valid) seen++;
    end
    n_chk++; if (seen != 0) begin n_err++; $display("FAIL bp_single_result got=%0d exp=0", seen); end
  endtask

  task automatic test_early_ready();
    int lat;
    ifc.out_ready = 1'b1;
    start_div(-25'sd100, 10'sd9);
    wait_out(lat);
    n_chk++; if (lat != 26) begin n_err++; $display("FAIL early_latency got=%0d exp=26", lat); end
    n_chk++; if (ifc.quotient !== -14'sd11 || ifc.remainder !== -10'sd1) begin
      n_err++; $display("FAIL early_result got q=%0d r=%0d exp q=-11 r=-1", $signed(ifc.quotient), $signed(ifc.remainder));
    end
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    n_chk++; if (ifc.out_valid !== 1'b0) begin n_err++; $display("FAIL early_consume got=%b exp=0", ifc.out_valid); end
  endtask

  task automatic test_reset_mid();
    int lat;
    start_div(25'sd1000, 10'sd7);
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (ifc.out_valid !== 1'b0 || ifc.quotient !== 14'd0 || ifc.remainder !== 10'd0 ||
                 ifc.div_by_zero !== 1'b0 || ifc.overflow !== 1'b0) begin
      n_err++; $display("FAIL midrst_outputs got v=%b q=%0d r=%0d dz=%b ov=%b exp all 0",
                        ifc.out_valid, ifc.quotient, ifc.remainder, ifc.div_by_zero, ifc.overflow);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (ifc.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got=%b exp=1", ifc.in_ready); end
    start_div(-25'sd1000, 10'sd7);
    wait_out(lat);
    n_chk++; if (lat != 26 || ifc.quotient !== -14'sd142 || ifc.remainder !== -10'sd6) begin
      n_err++; $display("FAIL midrst_next got lat=%0d q=%0d r=%0d exp lat=26 q=-142 r=-6",
                        lat, $signed(ifc.quotient), $signed(ifc.remainder));
    end
    consume();
  endtask

  initial begin
    n_err         = 0;
    n_chk         = 0;
    rst_n         = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    ifc.dividend  = '0;
    ifc.divisor   = '0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_early_ready();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
